// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parser state encoding and default frame header
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_HOLD
  } parser_state_t;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_payload_buf.sv
// rtl/uart_payload_buf.sv - 16x8 payload store, synchronous write, asynchronous read
module uart_payload_buf (
  input  logic       clk,
  input  logic       we,
  input  logic [3:0] waddr,
  input  logic [7:0] wdata,
  input  logic [3:0] raddr,
  output logic [7:0] rdata
);

  // Contents are deliberately not reset; only frames that pass their checksum are exposed.
  logic [7:0] mem [16];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - HEADER/CMD/LEN/payload/CHK frame parser with hold-until-ack handoff
module uart_cmd_parser
  import uart_pkg::*;
#(
  parameter int         CLK_FRE       = 50,
  parameter int         UART_RATE     = 115200,
  parameter logic [7:0] HEADER        = DEFAULT_HEADER,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       recv_en,
  input  logic [7:0] recv_data,
  output logic       frame_valid,
  output logic [7:0] frame_cmd,
  output logic [3:0] frame_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       frame_ack,
  output logic       err_chk,
  output logic       err_timeout,
  output logic       err_ovr,
  output logic       busy
);

  localparam int CYC_PER_BIT = CLK_FRE * 1000000 / UART_RATE;
  localparam int TMO_LIMIT   = TIMEOUT_BYTES * 10 * CYC_PER_BIT;
  localparam int TW          = (TMO_LIMIT > 1) ? $clog2(TMO_LIMIT) : 1;

  parser_state_t state, state_next;

  logic [TW-1:0] tmo_cnt;
  logic [7:0]    sum_q;
  logic [3:0]    idx;
  logic          counting;
  logic          tmo_hit;
  logic          chk_ok;
  logic          buf_we;

  assign counting = (state == ST_CMD) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CHK);
  // A byte arriving on the expiry cycle wins over the timeout.
  assign tmo_hit  = counting && !recv_en && (tmo_cnt == TW'(TMO_LIMIT - 1));
  assign chk_ok   = (recv_data == sum_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (tmo_hit) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (recv_en && recv_data == HEADER) state_next = ST_CMD;
        ST_CMD:  if (recv_en) state_next = ST_LEN;
        ST_LEN:  if (recv_en) state_next = (recv_data[3:0] == 4'd0) ? ST_CHK : ST_DATA;
        ST_DATA: if (recv_en && idx == frame_len - 4'd1) state_next = ST_CHK;
        ST_CHK:  if (recv_en) state_next = chk_ok ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (frame_ack) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    frame_valid = (state == ST_HOLD);
    buf_we      = (state == ST_DATA) && recv_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cmd   <= 8'd0;
      frame_len   <= 4'd0;
      sum_q       <= 8'd0;
      idx         <= 4'd0;
      tmo_cnt     <= '0;
      err_chk     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovr     <= 1'b0;
    end else begin
      err_chk     <= (state == ST_CHK) && recv_en && !chk_ok;
      err_timeout <= tmo_hit;
      err_ovr     <= (state == ST_HOLD) && recv_en;

      if (recv_en || !counting || tmo_hit) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if (recv_en) begin
        case (state)
          ST_CMD: begin
            frame_cmd <= recv_data;
            sum_q     <= recv_data;
          end
          ST_LEN: begin
            frame_len <= recv_data[3:0];
            sum_q     <= sum_q + recv_data;
            idx       <= 4'd0;
          end
          ST_DATA: begin
            sum_q <= sum_q + recv_data;
            idx   <= idx + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  uart_payload_buf u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (recv_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       recv_en = 1'b0;
  logic [7:0] recv_data = 8'h00;
  logic [3:0] rd_addr = 4'd0;
  logic       frame_ack = 1'b0;
  logic       frame_valid, err_chk, err_timeout, err_ovr, busy;
  logic [7:0] frame_cmd, rd_data;
  logic [3:0] frame_len;

  int total = 0;
  int bad = 0;
  int n_chk = 0, n_tmo = 0, n_ovr = 0;
  int b_chk, b_tmo, b_ovr;

  // 10 cycles per bit -> timeout after 4*10*10 = 400 idle cycles
  uart_cmd_parser #(.CLK_FRE(1), .UART_RATE(100000)) dut (
    .clk(clk), .rst(rst), .recv_en(recv_en), .recv_data(recv_data),
    .frame_valid(frame_valid), .frame_cmd(frame_cmd), .frame_len(frame_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .frame_ack(frame_ack),
    .err_chk(err_chk), .err_timeout(err_timeout), .err_ovr(err_ovr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err_chk) n_chk++;
    if (err_timeout) n_tmo++;
    if (err_ovr) n_ovr++;
  end

  task automatic send_byte(input logic [7:0] b);
    recv_en = 1'b1;
    recv_data = b;
    @(negedge clk);
    recv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic snap();
    b_chk = n_chk; b_tmo = n_tmo; b_ovr = n_ovr;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_cmd !== 8'h00 || frame_len !== 4'h0) begin bad++; $display("FAIL reset_cmdlen got=%h/%h exp=00/0", frame_cmd, frame_len); end
    total++; if ({err_chk, err_timeout, err_ovr} !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", {err_chk, err_timeout, err_ovr}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_good_frame();
    snap();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ack_outside_hold busy got=%b exp=0", busy); end
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h45);
    total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL good_valid got=%b exp=1", frame_valid); end
    total++; if (frame_cmd !== 8'h10) begin bad++; $display("FAIL good_cmd got=%h exp=10", frame_cmd); end
    total++; if (frame_len !== 4'd2) begin bad++; $display("FAIL good_len got=%0d exp=2", frame_len); end
    rd_addr = 4'd0; #1;
    total++; if (rd_data !== 8'h11) begin bad++; $display("FAIL good_rd0 got=%h exp=11", rd_data); end
    rd_addr = 4'd1; #1;
    total++; if (rd_data !== 8'h22) begin bad++; $display("FAIL good_rd1 got=%h exp=22", rd_data); end
    idle(20);
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || busy !== 1'b1) begin bad++; $display("FAIL good_hold got=%b/%h/%b exp=1/10/1", frame_valid, frame_cmd, busy); end
    total++; if (n_chk != b_chk || n_tmo != b_tmo) begin bad++; $display("FAIL good_no_err got=%0d/%0d exp=0/0", n_chk - b_chk, n_tmo - b_tmo); end
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    total++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL good_ack got=%b/%b exp=0/0", frame_valid, busy); end
  endtask

  task automatic test_bad_chk();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h46);
    idle(1);
    total++; if (n_chk - b_chk != 1) begin bad++; $display("FAIL chk_pulse got=%0d exp=1", n_chk - b_chk); end
    total++; if (frame_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL chk_after got=%b/%b exp=0/0", frame_valid, busy); end
  endtask

  task automatic test_zero_len();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h07 || frame_len !== 4'd0) begin bad++; $display("FAIL zlen got=%b/%h/%0d exp=1/07/0", frame_valid, frame_cmd, frame_len); end
    do_ack();
    send_byte(8'h33);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL junk_ignored busy got=%b exp=0", busy); end
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h07 || frame_len !== 4'd0) begin bad++; $display("FAIL zlen_junk got=%b/%h/%0d exp=1/07/0", frame_valid, frame_cmd, frame_len); end
    do_ack();
  endtask

  task automatic test_timeout();
    snap();
    send_byte(8'hA5); send_byte(8'h10);
    idle(350);
    total++; if (busy !== 1'b1 || n_tmo != b_tmo) begin bad++; $display("FAIL tmo_early got=%b/%0d exp=1/0", busy, n_tmo - b_tmo); end
    idle(80);
    total++; if (n_tmo - b_tmo != 1) begin bad++; $display("FAIL tmo_pulse got=%0d exp=1", n_tmo - b_tmo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL tmo_idle busy got=%b exp=0", busy); end
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h45);
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h10) begin bad++; $display("FAIL tmo_recover got=%b/%h exp=1/10", frame_valid, frame_cmd); end
    do_ack();
    // byte lands on the exact expiry edge: it is taken and no timeout fires
    snap();
    send_byte(8'hA5);
    idle(398);
    send_byte(8'h10);
    idle(1);
    total++; if (n_tmo != b_tmo || busy !== 1'b1) begin bad++; $display("FAIL tmo_priority got=%0d/%b exp=0/1", n_tmo - b_tmo, busy); end
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'h45);
    total++; if (frame_valid !== 1'b1 || frame_len !== 4'd2) begin bad++; $display("FAIL tmo_priority_frame got=%b/%0d exp=1/2", frame_valid, frame_len); end
  endtask

  task automatic test_overrun();
    snap();
    send_byte(8'h99);
    idle(1);
    total++; if (n_ovr - b_ovr != 1) begin bad++; $display("FAIL ovr_pulse got=%0d exp=1", n_ovr - b_ovr); end
    rd_addr = 4'd0; #1;
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h10 || frame_len !== 4'd2 || rd_data !== 8'h11) begin bad++; $display("FAIL ovr_stable got=%b/%h/%0d/%h exp=1/10/2/11", frame_valid, frame_cmd, frame_len, rd_data); end
    recv_en = 1'b1; recv_data = 8'h55; frame_ack = 1'b1;
    @(negedge clk);
    recv_en = 1'b0; frame_ack = 1'b0;
    idle(1);
    total++; if (n_ovr - b_ovr != 2) begin bad++; $display("FAIL ovr_ack_pulse got=%0d exp=2", n_ovr - b_ovr); end
    rd_addr = 4'd1; #1;
    total++; if (frame_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 8'h22) begin bad++; $display("FAIL ovr_ack_state got=%b/%b/%h exp=0/0/22", frame_valid, busy, rd_data); end
  endtask

  task automatic test_reset_mid();
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    total++; if (n_chk != b_chk || n_tmo != b_tmo || n_ovr != b_ovr) begin bad++; $display("FAIL rst_mid_err got=%0d/%0d/%0d exp=0/0/0", n_chk - b_chk, n_tmo - b_tmo, n_ovr - b_ovr); end
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h01); send_byte(8'h33); send_byte(8'h54);
    rd_addr = 4'd0; #1;
    total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h20 || frame_len !== 4'd1 || rd_data !== 8'h33) begin bad++; $display("FAIL rst_mid_next got=%b/%h/%0d/%h exp=1/20/1/33", frame_valid, frame_cmd, frame_len, rd_data); end
    do_ack();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_zero_len();
    test_timeout();
    test_overrun();
    test_reset_mid();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
